// File: rtl/adc_qsys_nios2_gen2_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// adc_qsys_nios2_gen2_oci_dct_packer
//
// Producer end of the OCI data-trace-compression path. Packs 2-bit trace codes
// into a 30-bit shift buffer and hands full or flushed buffers downstream.
// Codes enter at the LSB end, so the oldest code sits at the MSB end of the
// valid region. A single-entry output register holds the word that is
// waiting for the downstream FIFO.
//
// Parameters:
//   FLUSH_ON_TEST_END - when nonzero, a rising edge on test_ending behaves
//                       like a flush pulse; when zero, test_ending is ignored
//
// Build option:
//   ADC_QSYS_DCT_PARITY_EN - when defined, word_data[34] carries even parity
//                            over word_data[33:0]; otherwise it is tied to 0
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   code_valid   trace code offered
//   code         2-bit trace code
//   code_ready   code is taken when code_valid && code_ready
//   flush        single-cycle request to emit the partial buffer
//   test_ending  simulation end indication (edge-detected)
//   dct_buffer   live packing buffer, newest code in [1:0]
//   dct_count    number of valid codes in dct_buffer, 0..15
//   word_valid   output word pending
//   word_ready   downstream accepts the word
//   word_data    {parity, count[3:0], buffer[29:0]}
// ---------------------------------------------------------------------------
module adc_qsys_nios2_gen2_oci_dct_packer #(
  parameter int unsigned FLUSH_ON_TEST_END = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        code_valid,
  input  logic [1:0]  code,
  output logic        code_ready,
  input  logic        flush,
  input  logic        test_ending,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [34:0] word_data
);

  localparam logic [3:0] COUNT_FULL = 4'd15;

  logic [29:0] buffer_q;
  logic [29:0] buffer_d;
  logic [3:0]  count_q;
  logic [3:0]  count_d;
  logic        word_valid_q;
  logic        word_valid_d;
  logic [34:0] word_data_q;
  logic [34:0] word_data_d;
  logic        flush_pending_q;
  logic        flush_pending_d;
  logic        test_ending_q;
  logic        test_ending_d;

  logic        out_free;
  logic        code_ready_int;
  logic        accept;
  logic        transfer;
  logic        test_end_rise;
  logic        flush_req;
  logic        word_parity;

  // The output register can take a new word when it is empty or is being
  // drained this very cycle. A full buffer only blocks input while the
  // output register cannot take it.
  always_comb begin
    out_free       = !word_valid_q || word_ready;
    code_ready_int = (count_q != COUNT_FULL) || out_free;
    accept         = code_valid && code_ready_int;
  end

  // A transfer is decided purely on registered state, so a flush or the
  // 15th code always produces its word one cycle after it is registered.
  always_comb begin
    transfer = ((count_q == COUNT_FULL) ||
                (flush_pending_q && (count_q != 4'd0))) && out_free;
  end

  // test_ending only matters on its rising edge, and only when the
  // parameter enables it; the parameter test folds away at elaboration.
  always_comb begin
    test_end_rise = (FLUSH_ON_TEST_END != 0) && test_ending && !test_ending_q;
    flush_req     = flush || test_end_rise;
    test_ending_d = test_ending;
  end

  // Even parity bit covering the count and buffer fields of the word.
`ifdef ADC_QSYS_DCT_PARITY_EN
  always_comb begin
    word_parity = ^{count_q, buffer_q};
  end
`else
  always_comb begin
    word_parity = 1'b0;
  end
`endif

  // Packing buffer. On a transfer the old contents leave for the output
  // register, and a code accepted in the same cycle starts the new buffer.
  always_comb begin
    buffer_d = buffer_q;
    count_d  = count_q;
    if (transfer) begin
      if (accept) begin
        buffer_d = {28'd0, code};
        count_d  = 4'd1;
      end else begin
        buffer_d = 30'd0;
        count_d  = 4'd0;
      end
    end else if (accept) begin
      buffer_d = {buffer_q[27:0], code};
      count_d  = count_q + 4'd1;
    end
  end

  // Flush bookkeeping. A new request wins over clearing so that a flush
  // landing on the same cycle as a transfer applies to the new buffer.
  // With nothing buffered and nothing arriving, the request is dropped so
  // that an empty word is never produced.
  always_comb begin
    flush_pending_d = flush_pending_q;
    if (flush_req) begin
      flush_pending_d = 1'b1;
    end else if (transfer || ((count_q == 4'd0) && !accept)) begin
      flush_pending_d = 1'b0;
    end
  end

  // Output register. A transfer always loads a new word (replacing one that
  // is draining in the same cycle); otherwise a drain empties the register.
  // The data is left untouched while the word waits for word_ready.
  always_comb begin
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    if (transfer) begin
      word_valid_d = 1'b1;
      word_data_d  = {word_parity, count_q, buffer_q};
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  // State register. Reset discards any partial buffer and pending word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer_q        <= 30'd0;
      count_q         <= 4'd0;
      word_valid_q    <= 1'b0;
      word_data_q     <= 35'd0;
      flush_pending_q <= 1'b0;
      test_ending_q   <= 1'b0;
    end else begin
      buffer_q        <= buffer_d;
      count_q         <= count_d;
      word_valid_q    <= word_valid_d;
      word_data_q     <= word_data_d;
      flush_pending_q <= flush_pending_d;
      test_ending_q   <= test_ending_d;
    end
  end

  always_comb begin
    code_ready = code_ready_int;
    dct_buffer = buffer_q;
    dct_count  = count_q;
    word_valid = word_valid_q;
    word_data  = word_data_q;
  end

endmodule

// File: tb/tb_adc_qsys_nios2_gen2_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// Bench for adc_qsys_nios2_gen2_oci_dct_packer.
// The reference model keeps the accepted codes as a plain list; a word is
// owed whenever the list reaches 15 codes or a flush (or test_ending rise)
// finds it non-empty. Owed words are queued and compared in order whenever
// the DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_adc_qsys_nios2_gen2_oci_dct_packer;

  localparam int unsigned FLUSH_TE = 1;

  logic        clk;
  logic        reset_n;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic        word_ready;
  logic [34:0] word_data;

  int n_vectors;
  int n_miscompares;

  logic [1:0]  model_codes[$];
  logic [34:0] exp_q[$];
  logic        te_prev;
  logic        hold_valid;
  logic [34:0] hold_data;

  adc_qsys_nios2_gen2_oci_dct_packer #(
    .FLUSH_ON_TEST_END(FLUSH_TE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (code_ready),
    .flush      (flush),
    .test_ending(test_ending),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [34:0] actual,
                             input logic [34:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return just after the capturing edge.
  task automatic applyStimulus(input logic v, input logic [1:0] c,
                               input logic f, input logic te,
                               input logic wr);
    code_valid  = v;
    code        = c;
    flush       = f;
    test_ending = te;
    word_ready  = wr;
    @(posedge clk);
    #1;
  endtask

  // Turn the model's code list into the word the DUT owes us.
  task automatic emitWord();
    logic [29:0] b;
    logic [3:0]  n;
    logic        p;
    b = 30'd0;
    foreach (model_codes[i]) b = (b << 2) | 30'(model_codes[i]);
    n = 4'(model_codes.size());
`ifdef ADC_QSYS_DCT_PARITY_EN
    p = ^{n, b};
`else
    p = 1'b0;
`endif
    exp_q.push_back({p, n, b});
    model_codes.delete();
  endtask

  // Monitor: samples mid-cycle, scores output handshakes against the queue,
  // checks held words stay stable, and feeds accepted codes to the model.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_codes.delete();
      exp_q.delete();
      te_prev    = 1'b0;
      hold_valid = 1'b0;
      hold_data  = 35'd0;
    end else begin
      if (hold_valid) begin
        checkOutput("held_valid", 35'(word_valid), 35'd1);
        checkOutput("held_data", word_data, hold_data);
      end
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_vectors++;
          n_miscompares++;
          $display("[TB] FAIL unexpected_word actual=%h required=none", word_data);
        end else begin
          checkOutput("word_data", word_data, exp_q.pop_front());
        end
      end
      hold_valid = word_valid && !word_ready;
      hold_data  = word_data;
      if (code_valid && code_ready) begin
        model_codes.push_back(code);
        if (model_codes.size() == 15) emitWord();
      end
      if (flush || ((FLUSH_TE != 0) && test_ending && !te_prev)) begin
        if (model_codes.size() != 0) emitWord();
      end
      te_prev = test_ending;
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_word_valid"}, 35'(word_valid), 35'd0);
    checkOutput({tag, "_word_data"}, word_data, 35'd0);
    checkOutput({tag, "_dct_count"}, 35'(dct_count), 35'd0);
    checkOutput({tag, "_dct_buffer"}, 35'(dct_buffer), 35'd0);
    checkOutput({tag, "_code_ready"}, 35'(code_ready), 35'd1);
  endtask

  initial begin
    logic       te_level;
    logic       new_te;
    logic       fl;
    logic       idle_next;
    int         budget;

    n_vectors     = 0;
    n_miscompares = 0;
    code_valid    = 1'b0;
    code          = 2'b00;
    flush         = 1'b0;
    test_ending   = 1'b0;
    word_ready    = 1'b0;
    reset_n       = 1'b1;
    #2 reset_n = 1'b0;
    #1 checkResetState("init_reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(0, 2'b00, 0, 0, 1);

    // Full buffer of 2'b10 codes with the output free.
    $display("[TB] full buffer");
    for (int i = 0; i < 15; i++) applyStimulus(1, 2'b10, 0, 0, 1);
    checkOutput("full_count15", 35'(dct_count), 35'd15);
    checkOutput("full_not_yet_valid", 35'(word_valid), 35'd0);
    applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("full_valid", 35'(word_valid), 35'd1);
    checkOutput("full_word", 35'(word_data[33:0]), 35'({4'hF, 30'h2AAAAAAA}));
    checkOutput("full_count0", 35'(dct_count), 35'd0);
    applyStimulus(0, 2'b00, 0, 0, 1);

    // Flush of three codes, then a flush with nothing buffered.
    $display("[TB] flush");
    applyStimulus(1, 2'b11, 0, 0, 1);
    applyStimulus(1, 2'b00, 0, 0, 1);
    applyStimulus(1, 2'b01, 0, 0, 1);
    applyStimulus(0, 2'b00, 1, 0, 1);
    applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("flush_valid", 35'(word_valid), 35'd1);
    checkOutput("flush_word", 35'(word_data[33:0]), 35'({4'h3, 30'h00000031}));
    applyStimulus(0, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b00, 1, 0, 1);
    applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("empty_flush_no_word", 35'(word_valid), 35'd0);
    applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("empty_flush_still_none", 35'(word_valid), 35'd0);

    // Backpressure: 30 codes against a blocked output register.
    $display("[TB] backpressure");
    for (int i = 0; i < 30; i++) applyStimulus(1, 2'($urandom_range(3, 0)), 0, 0, 0);
    checkOutput("bp_word_valid", 35'(word_valid), 35'd1);
    checkOutput("bp_count15", 35'(dct_count), 35'd15);
    checkOutput("bp_code_ready_low", 35'(code_ready), 35'd0);
    code_valid = 1'b0;
    word_ready = 1'b1;
    #1 checkOutput("bp_code_ready_back", 35'(code_ready), 35'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 0, 0, 1);

    // 14 codes, then the 15th together with a flush: one word only.
    $display("[TB] simultaneous events");
    for (int i = 0; i < 14; i++) applyStimulus(1, 2'($urandom_range(3, 0)), 0, 0, 1);
    applyStimulus(1, 2'($urandom_range(3, 0)), 1, 0, 1);
    applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("sim_word_count15", 35'(word_data[33:30]), 35'd15);
    applyStimulus(0, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("sim_single_word", 35'(word_valid), 35'd0);
    // A transfer overlapping an accept leaves one code in the buffer.
    for (int i = 0; i < 16; i++) applyStimulus(1, 2'($urandom_range(3, 0)), 0, 0, 1);
    checkOutput("xfer_accept_count1", 35'(dct_count), 35'd1);
    applyStimulus(0, 2'b00, 1, 0, 1);
    applyStimulus(0, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b00, 0, 0, 1);

    // test_ending rising edge after five codes.
    $display("[TB] test_ending");
    for (int i = 0; i < 5; i++) applyStimulus(1, 2'($urandom_range(3, 0)), 0, 0, 1);
    applyStimulus(0, 2'b00, 0, 1, 1);
    applyStimulus(0, 2'b00, 0, 1, 1);
    checkOutput("te_valid", 35'(word_valid), 35'd1);
    checkOutput("te_count5", 35'(word_data[33:30]), 35'd5);
`ifdef ADC_QSYS_DCT_PARITY_EN
    checkOutput("te_parity", 35'(word_data[34]), 35'(^word_data[33:0]));
`endif
    applyStimulus(0, 2'b00, 0, 1, 1);
    applyStimulus(0, 2'b00, 0, 0, 1);

    // Random traffic with random backpressure, no flushes.
    $display("[TB] random backpressure");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 0, 0,
                    1'($urandom_range(3, 0) != 0));

    // Random traffic with flushes and test_ending toggles; each flush is
    // followed by one idle cycle so the flushed word is well defined.
    $display("[TB] random flush");
    te_level  = 1'b0;
    idle_next = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (idle_next) begin
        applyStimulus(0, 2'b00, 0, te_level, 1);
        idle_next = 1'b0;
      end else begin
        fl     = ($urandom_range(11, 0) == 0);
        new_te = te_level;
        if ($urandom_range(9, 0) == 0) new_te = !te_level;
        if (fl || (new_te && !te_level)) idle_next = 1'b1;
        te_level = new_te;
        applyStimulus(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), fl,
                      te_level, 1);
      end
    end
    applyStimulus(0, 2'b00, 0, 0, 1);

    // Reset with a word pending: everything is discarded at once.
    $display("[TB] mid-stream reset");
    for (int i = 0; i < 16; i++) applyStimulus(1, 2'($urandom_range(3, 0)), 0, 0, 0);
    checkOutput("pre_reset_word_valid", 35'(word_valid), 35'd1);
    code_valid = 1'b0;
    reset_n    = 1'b0;
    #1 checkResetState("mid_reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("post_reset_no_word", 35'(word_valid), 35'd0);

    // Final flush and drain with a bounded wait.
    for (int i = 0; i < 7; i++) applyStimulus(1, 2'($urandom_range(3, 0)), 0, 0, 1);
    applyStimulus(0, 2'b00, 1, 0, 1);
    budget = 0;
    while ((exp_q.size() != 0 || word_valid) && budget < 200) begin
      applyStimulus(0, 2'b00, 0, 0, 1);
      budget++;
    end
    applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("drain_queue_empty", 35'(exp_q.size()), 35'd0);
    checkOutput("drain_model_empty", 35'(model_codes.size()), 35'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
